// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - shared NES system types and bus address constants
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } oam_dma_state_t;

  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite OAM DMA controller and CPU/DMA system bus arbiter
module oam_dma
  import nes_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = ADDR_OAMDMA,
  parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_d_out,
  input  logic [7:0]  bus_d_in,
  output logic        cpu_ready,
  output logic [15:0] bus_addr,
  output logic        bus_write,
  output logic [7:0]  bus_d_out,
  output logic        dma_active
);

  oam_dma_state_t state, state_next;
  logic           parity;
  logic [7:0]     page;
  logic [7:0]     idx;
  logic [7:0]     data;
  logic           trigger;

  assign trigger = (state == IDLE) && cpu_write && (cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      parity <= 1'b0;
      page   <= 8'h00;
      idx    <= 8'h00;
      data   <= 8'h00;
    end else begin
      state  <= state_next;
      parity <= ~parity;
      if (trigger) begin
        page <= cpu_d_out;
        idx  <= 8'h00;
      end
      if (state == READ) begin
        data <= bus_d_in;
      end
      if (state == WRITE) begin
        idx <= idx + 8'd1;
      end
    end
  end

  // Outputs depend on state and CPU signals only; bus_d_in reaches nothing combinationally.
  always_comb begin
    state_next = state;
    bus_addr   = cpu_addr;
    bus_write  = cpu_write;
    bus_d_out  = cpu_d_out;
    unique case (state)
      IDLE: begin
        if (trigger) state_next = HALT;
      end
      HALT: begin
        // The CPU only honours ready on reads, so stay here through its pending writes.
        if (!cpu_write) state_next = parity ? READ : ALIGN;
      end
      ALIGN: begin
        bus_write  = 1'b0;
        state_next = READ;
      end
      READ: begin
        bus_addr   = {page, idx};
        bus_write  = 1'b0;
        bus_d_out  = data;
        state_next = WRITE;
      end
      WRITE: begin
        bus_addr   = OAM_DATA_ADDR;
        bus_write  = 1'b1;
        bus_d_out  = data;
        state_next = (idx == 8'hFF) ? IDLE : READ;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cpu_ready  = (state == IDLE);
  assign dma_active = (state != IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - directed self-checking bench for oam_dma
module tb_oam_dma;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_write;
  logic [7:0]  cpu_d_out;
  logic [7:0]  bus_d_in;
  logic        cpu_ready;
  logic [15:0] bus_addr;
  logic        bus_write;
  logic [7:0]  bus_d_out;
  logic        dma_active;

  int checks;
  int failures;
  logic par;

  oam_dma dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_write  (cpu_write),
    .cpu_d_out  (cpu_d_out),
    .bus_d_in   (bus_d_in),
    .cpu_ready  (cpu_ready),
    .bus_addr   (bus_addr),
    .bus_write  (bus_write),
    .bus_d_out  (bus_d_out),
    .dma_active (dma_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference parity: 0 in the first cycle after reset, toggling every cycle.
  always @(posedge clk or negedge reset) begin
    if (!reset) par <= 1'b0;
    else        par <= ~par;
  end

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    if (a[15:8] == 8'h03) return a[7:0] ^ 8'hA5;
    return a[7:0] + a[15:8];
  endfunction

  assign bus_d_in = mem_byte(bus_addr);

  // Runs one DMA from trigger to release and reports what the bus did.
  task automatic do_transfer(
    input  logic [7:0]  pg,
    input  logic        want_par,
    input  int          extra_writes,
    input  logic        retrigger,
    output int          halt_cycles,
    output int          first_read_cyc,
    output int          first_read_par,
    output logic [15:0] first_read_addr,
    output int          n_writes,
    output int          addr_errs,
    output int          data_errs
  );
    logic [15:0] prev_addr;
    logic        done;
    halt_cycles     = 0;
    first_read_cyc  = -1;
    first_read_par  = -1;
    first_read_addr = 16'hFFFF;
    n_writes        = 0;
    addr_errs       = 0;
    data_errs       = 0;
    prev_addr       = 16'h0000;
    done            = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (par == want_par) break;
    end
    cpu_addr  = 16'h4014;
    cpu_write = 1'b1;
    cpu_d_out = pg;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (c <= extra_writes) begin
        cpu_addr  = retrigger ? 16'h4014 : 16'h0300;
        cpu_write = 1'b1;
        cpu_d_out = 8'hEE;
      end else begin
        cpu_addr  = 16'h8123;
        cpu_write = 1'b0;
        cpu_d_out = 8'h00;
      end
      #1;
      if (cpu_ready) begin
        done = 1'b1;
        break;
      end
      halt_cycles++;
      if (c > extra_writes + 1 && first_read_cyc < 0 && !bus_write && bus_addr[15:8] == pg) begin
        first_read_cyc  = c;
        first_read_par  = int'(par);
        first_read_addr = bus_addr;
      end
      if (bus_write && !cpu_write && bus_addr == 16'h2004) begin
        if (prev_addr !== {pg, n_writes[7:0]}) addr_errs++;
        if (bus_d_out !== mem_byte({pg, n_writes[7:0]})) data_errs++;
        n_writes++;
      end
      prev_addr = bus_addr;
    end
    if (!done) begin
      $display("FAIL transfer_timeout cpu_ready=%0b required=1 after 2000 cycles", cpu_ready);
      failures++;
    end
    checks++;
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    cpu_addr  = 16'h8000;
    cpu_write = 1'b0;
    cpu_d_out = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (cpu_ready !== 1'b1) begin
        $display("FAIL reset_ready cycle=%0d got=%0b required=1", i, cpu_ready);
        failures++;
      end
      checks++;
      if (dma_active !== 1'b0) begin
        $display("FAIL reset_active cycle=%0d got=%0b required=0", i, dma_active);
        failures++;
      end
      checks++;
      if (bus_addr !== 16'h8000) begin
        $display("FAIL reset_bus_addr cycle=%0d got=%h required=8000", i, bus_addr);
        failures++;
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_even_trigger;
    int h, frc, frp, nw, ae, de;
    logic [15:0] fra;
    do_transfer(8'h02, 1'b0, 0, 1'b0, h, frc, frp, fra, nw, ae, de);
    checks++;
    if (h !== 513) begin $display("FAIL even_halt got=%0d required=513", h); failures++; end
    checks++;
    if (frc !== 2) begin $display("FAIL even_first_read_cycle got=%0d required=2", frc); failures++; end
    checks++;
    if (fra !== 16'h0200) begin $display("FAIL even_first_addr got=%h required=0200", fra); failures++; end
    checks++;
    if (nw !== 256) begin $display("FAIL even_writes got=%0d required=256", nw); failures++; end
    checks++;
    if (ae !== 0) begin $display("FAIL even_read_addrs errors=%0d required=0", ae); failures++; end
  endtask

  task automatic test_odd_trigger;
    int h, frc, frp, nw, ae, de;
    logic [15:0] fra;
    do_transfer(8'h02, 1'b1, 0, 1'b0, h, frc, frp, fra, nw, ae, de);
    checks++;
    if (h !== 514) begin $display("FAIL odd_halt got=%0d required=514", h); failures++; end
    checks++;
    if (frc !== 3) begin $display("FAIL odd_first_read_cycle got=%0d required=3", frc); failures++; end
    checks++;
    if (frp !== 0) begin $display("FAIL odd_first_read_parity got=%0d required=0", frp); failures++; end
    checks++;
    if (nw !== 256) begin $display("FAIL odd_writes got=%0d required=256", nw); failures++; end
    checks++;
    if (ae !== 0) begin $display("FAIL odd_read_addrs errors=%0d required=0", ae); failures++; end
  endtask

  task automatic test_data_integrity;
    int h, frc, frp, nw, ae, de;
    logic [15:0] fra;
    do_transfer(8'h03, 1'b0, 0, 1'b0, h, frc, frp, fra, nw, ae, de);
    checks++;
    if (de !== 0) begin $display("FAIL data_values errors=%0d required=0", de); failures++; end
    checks++;
    if (nw !== 256) begin $display("FAIL data_writes got=%0d required=256", nw); failures++; end
    checks++;
    if (dut.idx !== 8'h00) begin $display("FAIL data_idx_wrap got=%h required=00", dut.idx); failures++; end
  endtask

  task automatic test_extended_halt;
    int h, frc, frp, nw, ae, de;
    logic [15:0] fra;
    do_transfer(8'h02, 1'b0, 2, 1'b1, h, frc, frp, fra, nw, ae, de);
    checks++;
    if (frc !== 4) begin $display("FAIL ext_first_read_cycle got=%0d required=4", frc); failures++; end
    checks++;
    if (h !== 515) begin $display("FAIL ext_halt got=%0d required=515", h); failures++; end
    checks++;
    if (dut.page !== 8'h02) begin $display("FAIL ext_page got=%h required=02", dut.page); failures++; end
    checks++;
    if (ae !== 0) begin $display("FAIL ext_read_addrs errors=%0d required=0", ae); failures++; end
  endtask

  task automatic test_no_trigger;
    @(negedge clk);
    cpu_addr  = 16'h4015;
    cpu_write = 1'b1;
    cpu_d_out = 8'h07;
    @(negedge clk);
    cpu_addr  = 16'h8123;
    cpu_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (cpu_ready !== 1'b1 || dma_active !== 1'b0) begin
        $display("FAIL no_trigger_4015 cycle=%0d ready=%0b active=%0b required ready=1 active=0",
                 i, cpu_ready, dma_active);
        failures++;
      end
    end
  endtask

  task automatic test_reset_mid_transfer;
    int h, frc, frp, nw, ae, de;
    logic [15:0] fra;
    logic        hit;
    hit = 1'b0;
    @(negedge clk);
    cpu_addr  = 16'h4014;
    cpu_write = 1'b1;
    cpu_d_out = 8'h02;
    @(negedge clk);
    cpu_addr  = 16'h8123;
    cpu_write = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (dut.idx == 8'h40) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin $display("FAIL midreset_reach_idx40 idx=%h required=40", dut.idx); failures++; end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (cpu_ready !== 1'b1) begin $display("FAIL midreset_ready got=%0b required=1", cpu_ready); failures++; end
    checks++;
    if (dma_active !== 1'b0) begin $display("FAIL midreset_active got=%0b required=0", dma_active); failures++; end
    checks++;
    if (bus_addr !== 16'h8123) begin $display("FAIL midreset_bus_addr got=%h required=8123", bus_addr); failures++; end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_transfer(8'h05, 1'b0, 0, 1'b0, h, frc, frp, fra, nw, ae, de);
    checks++;
    if (fra !== 16'h0500) begin $display("FAIL restart_first_addr got=%h required=0500", fra); failures++; end
    checks++;
    if (nw !== 256 || ae !== 0) begin
      $display("FAIL restart_transfer writes=%0d addr_errors=%0d required 256 and 0", nw, ae);
      failures++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset;
    test_even_trigger;
    test_odd_trigger;
    test_data_integrity;
    test_extended_halt;
    test_no_trigger;
    test_reset_mid_transfer;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite OAM DMA controller and bus arbiter between the 6502 `cpu` core and the system bus.
- A CPU write to $4014 latches a source page and halts the CPU through its `ready` input. The block then takes the bus and copies 256 bytes from {page,00..FF} to the PPU OAM data port $2004.
- On completion the bus and `ready` return to the CPU.
- Sits at top level: CPU bus outputs enter here, and the muxed bus leaves to memory/PPU decode.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers a transfer.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.

Ports:
- clk  in  1  system clock (one CPU cycle per edge)
- reset  in  1  asynchronous, active-low reset
- cpu_addr  in  16  CPU address output
- cpu_write  in  1  CPU write strobe
- cpu_d_out  in  8  CPU write data
- bus_d_in  in  8  read data returned from the bus (also routed to the CPU at top level)
- cpu_ready  out  1  drives CPU `ready`; 0 = halt
- bus_addr  out  16  muxed bus address
- bus_write  out  1  muxed write strobe
- bus_d_out  out  8  muxed write data
- dma_active  out  1  1 in any state except IDLE

Behaviour:
- One clock; reset is asynchronous and active-low, ports named clk and reset.
- Reset (asserted at any time, including mid-transfer), immediate:
  - state=IDLE, parity=0, page=0, idx=0, data=0.
  - cpu_ready=1, dma_active=0, bus mirrors CPU.
- parity flop toggles every clk from reset. READ cycles occur only when parity=0.
- Registers: page[7:0], idx[7:0] (wraps), data[7:0].
- States:
  - IDLE: bus_addr/bus_write/bus_d_out = cpu_addr/cpu_write/cpu_d_out; cpu_ready=1.
    - If cpu_write && cpu_addr==DMA_REG_ADDR: page<=cpu_d_out, idx<=0, next HALT.
    - The triggering write itself completes on the bus this cycle.
  - HALT: cpu_ready=0; bus mirrors CPU. The CPU ignores ready during writes, so HALT persists while cpu_write=1.
    - First HALT cycle with cpu_write=0 is the halt/dummy read: the CPU address is passed through and its data discarded by the CPU.
    - From that cycle: if parity==0 next ALIGN, else next READ.
  - ALIGN: one cycle; cpu_ready=0; bus_addr=cpu_addr, bus_write=0; next READ.
  - READ: bus_addr={page,idx}, bus_write=0; data<=bus_d_in at clock edge; next WRITE.
  - WRITE: bus_addr=OAM_DATA_ADDR, bus_write=1, bus_d_out=data; idx<=idx+1.
    - If idx==8'hFF next IDLE, else next READ.
- cpu_ready = (state==IDLE), decoded from the state register only, never from bus inputs.
- cpu_ready returns to 1 in the cycle after the final WRITE.
- Halt length, counted from the trigger cycle T:
  - Triggering write at parity 0, CPU reads at T+1: halted T+1..T+513 (513 cycles).
  - Triggering write at parity 1: 514 cycles.
  - Each extra CPU write cycle after the trigger adds one cycle.
- A write to DMA_REG_ADDR while not IDLE (e.g. RMW second write in HALT) is ignored; page is not re-latched.
- Writes to other addresses never trigger.
- No combinational path from bus_d_in to any output.

Decomposition:
- Shared package nes_pkg:
  - enum oam_dma_state_t {IDLE, HALT, ALIGN, READ, WRITE}.
  - Constants ADDR_OAMDMA=16'h4014, ADDR_OAMDATA=16'h2004.
- Single module, no sub-module; the bus mux is inline combinational logic keyed on state.

Test Plan:
- Reset: hold reset=0 for 3 cycles with CPU driving addr 16'h8000 -> cpu_ready=1, dma_active=0, bus_addr=16'h8000; assert reset=0 mid-cycle asynchronously -> outputs change before next edge.
- Even trigger: write 8'h02 to $4014 at parity 0, CPU reads next cycle -> cpu_ready=0 for exactly 513 cycles; reads at 16'h0200..16'h02FF each followed by a write to 16'h2004.
- Odd trigger: same with parity 1 -> one ALIGN cycle, 514 halted cycles, first READ at parity 0.
- Data integrity: memory model with page 8'h03 byte[i]=i^8'hA5 -> the 256 bus_d_out values on $2004 writes equal i^8'hA5 in order i=0..255; idx wraps to 0 at end.
- Extended halt and ignored triggers:
  - CPU holds cpu_write=1 for 2 cycles after the trigger -> HALT lasts 3 cycles.
  - A second $4014 write in HALT leaves page unchanged.
  - A write to $4015 never triggers.
- Reset mid-transfer: assert reset when idx=8'h40 -> immediate IDLE, cpu_ready=1; a new trigger with page 8'h05 restarts at 16'h0500.
